// File: rtl/hamming_pkg.sv
// Shared SECDED constants: code-size modes, per-mode K/P/N and parity column tables.
// The column tables are reused by the decoder's syndrome logic.
package hamming_pkg;

    typedef enum logic [1:0] {
        MODE_SMALL   = 2'b00,
        MODE_MEDIUM  = 2'b01,
        MODE_LARGE   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } code_mode_e;

    localparam int K_SMALL  = 4;
    localparam int P_SMALL  = 4;
    localparam int N_SMALL  = 8;
    localparam int K_MEDIUM = 11;
    localparam int P_MEDIUM = 5;
    localparam int N_MEDIUM = 16;
    localparam int K_LARGE  = 26;
    localparam int P_LARGE  = 6;
    localparam int N_LARGE  = 32;

    // Column of data bit i: the i-th ascending (P-1)-bit value with popcount >= 2.
    localparam logic [P_SMALL-2:0] COL_SMALL [K_SMALL] = '{3'd3, 3'd5, 3'd6, 3'd7};

    localparam logic [P_MEDIUM-2:0] COL_MEDIUM [K_MEDIUM] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    localparam logic [P_LARGE-2:0] COL_LARGE [K_LARGE] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational SECDED codeword builder: parity bits low, data above, zero-extended.
// Illegal mode yields an all-zero codeword.
module hamming_parity_gen
    import hamming_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [K_LARGE-1:0]    i_data,
    input  code_mode_e            i_mode,
    output logic [DATA_WIDTH-1:0] o_codeword
);

    logic [P_SMALL-1:0]  w_par_s;
    logic [P_MEDIUM-1:0] w_par_m;
    logic [P_LARGE-1:0]  w_par_l;
    logic [N_LARGE-1:0]  w_cw;

    always_comb begin
        w_par_s = '0;
        w_par_m = '0;
        w_par_l = '0;
        for (int i = 0; i < K_SMALL; i++)
            for (int r = 0; r < P_SMALL - 1; r++)
                if (COL_SMALL[i][r]) w_par_s[r] = w_par_s[r] ^ i_data[i];
        for (int i = 0; i < K_MEDIUM; i++)
            for (int r = 0; r < P_MEDIUM - 1; r++)
                if (COL_MEDIUM[i][r]) w_par_m[r] = w_par_m[r] ^ i_data[i];
        for (int i = 0; i < K_LARGE; i++)
            for (int r = 0; r < P_LARGE - 1; r++)
                if (COL_LARGE[i][r]) w_par_l[r] = w_par_l[r] ^ i_data[i];
        // Top parity bit makes the whole codeword even.
        w_par_s[P_SMALL-1]  = ^{i_data[K_SMALL-1:0],  w_par_s[P_SMALL-2:0]};
        w_par_m[P_MEDIUM-1] = ^{i_data[K_MEDIUM-1:0], w_par_m[P_MEDIUM-2:0]};
        w_par_l[P_LARGE-1]  = ^{i_data[K_LARGE-1:0],  w_par_l[P_LARGE-2:0]};
    end

    always_comb begin
        w_cw = '0;
        case (i_mode)
            MODE_SMALL:  w_cw = N_LARGE'({i_data[K_SMALL-1:0],  w_par_s});
            MODE_MEDIUM: w_cw = N_LARGE'({i_data[K_MEDIUM-1:0], w_par_m});
            MODE_LARGE:  w_cw = {i_data[K_LARGE-1:0], w_par_l};
            default:     w_cw = '0;
        endcase
    end

    assign o_codeword = DATA_WIDTH'(w_cw);

endmodule

// File: rtl/hamming_encoder.sv
// Two-stage streaming SECDED encoder with valid/ready on both sides,
// illegal-mode flagging and a saturating count of delivered codewords.
module hamming_encoder
    import hamming_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            code_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] codeword_out,
    output logic                  mode_err,
    output logic [CNT_WIDTH-1:0]  enc_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid holds its word until that edge, ready may depend on the far side.
    logic                  r_s1_valid;
    logic [K_LARGE-1:0]    r_s1_data;
    code_mode_e            r_s1_mode;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_cw;
    logic                  r_s2_err;
    logic [CNT_WIDTH-1:0]  r_enc_count;

    logic                  w_s2_load;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [DATA_WIDTH-1:0] w_cw;
    logic                  w_unused_hi;

    assign w_s2_load   = !r_s2_valid || out_ready;
    assign in_ready    = !rst && (!r_s1_valid || w_s2_load);
    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = r_s2_valid && out_ready;
    assign w_unused_hi = ^data_in[DATA_WIDTH-1:K_LARGE];

    hamming_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity_gen (
        .i_data     (r_s1_data),
        .i_mode     (r_s1_mode),
        .o_codeword (w_cw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= MODE_SMALL;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (w_in_xfer) begin
                r_s1_data <= data_in[K_LARGE-1:0];
                r_s1_mode <= code_mode_e'(code_mode);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_cw    <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_cw  <= w_cw;
                r_s2_err <= (r_s1_mode == MODE_ILLEGAL);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_enc_count <= '0;
        else if (w_out_xfer && r_enc_count != CNT_MAX)
            r_enc_count <= r_enc_count + 1'b1;
    end

    assign out_valid    = r_s2_valid;
    assign codeword_out = r_s2_cw;
    assign mode_err     = r_s2_err;
    assign enc_count    = r_enc_count;

endmodule

// File: tb/tb_hamming_encoder.sv
// Scoreboard bench for hamming_encoder: drivers push expected words, a monitor pops on output transfers.
module tb_hamming_encoder;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    code_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] codeword_out;
    logic          mode_err;
    logic [CW-1:0] enc_count;

    logic          sat_in_valid = 1'b0;
    logic          sat_in_ready;
    logic          sat_out_valid;
    logic [DW-1:0] sat_codeword;
    logic          sat_mode_err;
    logic [1:0]    sat_enc_count;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_lat = 0;
    bit rdy_rand = 0;
    bit prev_stall = 0;
    logic [DW:0] prev_out;
    logic [DW:0] exp_q[$];
    int          lat_q[$];

    hamming_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .code_mode(code_mode), .out_valid(out_valid),
        .out_ready(out_ready), .codeword_out(codeword_out), .mode_err(mode_err),
        .enc_count(enc_count)
    );

    // Narrow counter instance so saturation is reachable in a few words.
    hamming_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .data_in(32'h5), .code_mode(2'b00), .out_valid(sat_out_valid),
        .out_ready(1'b1), .codeword_out(sat_codeword), .mode_err(sat_mode_err),
        .enc_count(sat_enc_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rdy_rand) begin #1 out_ready = 1'($urandom_range(0, 1)); end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW:0] model(input logic [DW-1:0] d, input logic [1:0] m);
        int k, p, i;
        logic [5:0]  par;
        logic [DW-1:0] cw;
        logic ov;
        if (m == 2'b11) return {1'b1, {DW{1'b0}}};
        k = (m == 2'b00) ? 4 : (m == 2'b01) ? 11 : 26;
        p = (m == 2'b00) ? 4 : (m == 2'b01) ? 5 : 6;
        par = '0;
        i = 0;
        for (int unsigned v = 3; i < k; v++) begin
            if ($countones(v) >= 2) begin
                for (int r = 0; r < p - 1; r++) if (v[r]) par[r] = par[r] ^ d[i];
                i++;
            end
        end
        ov = 1'b0;
        for (int j = 0; j < k; j++) ov = ov ^ d[j];
        for (int r = 0; r < p - 1; r++) ov = ov ^ par[r];
        par[p-1] = ov;
        cw = '0;
        for (int j = 0; j < k; j++) cw[p+j] = d[j];
        for (int r = 0; r < p; r++) cw[r] = par[r];
        return {1'b0, cw};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic [DW:0] e);
        bit acc;
        int ca;
        acc = 0;
        ca = 0;
        in_valid = 1'b1;
        data_in = d;
        code_mode = m;
        for (int w = 0; w < 200 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready;
            ca = cyc;
            @(posedge clk);
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0d expected 1", in_ready);
        end else begin
            exp_q.push_back(e);
            lat_q.push_back(ca);
        end
        #1;
    endtask

    task automatic drain();
        for (int w = 0; w < 1000 && exp_q.size() != 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [DW:0] e;
        int a;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 64'(out_valid), 64'(1));
                check("stall_hold_word", 64'({mode_err, codeword_out}), 64'(prev_out));
            end
            check("in_ready_occupancy", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none", {mode_err, codeword_out});
                end else begin
                    e = exp_q.pop_front();
                    a = lat_q.pop_front();
                    check("codeword", 64'({mode_err, codeword_out}), 64'(e));
                    if (chk_lat) check("latency", 64'(cyc - a), 64'(2));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {mode_err, codeword_out};
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] d;
        logic [1:0] m;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_codeword", 64'(codeword_out), 64'(0));
        check("rst_mode_err", 64'(mode_err), 64'(0));
        check("rst_enc_count", 64'(enc_count), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        chk_lat = 1;
        send(32'h1,        2'b00, {1'b0, 32'h0000001B});
        send(32'hF,        2'b00, {1'b0, 32'h000000FF});
        send(32'hFFFFFFF1, 2'b00, {1'b0, 32'h0000001B});
        send(32'h001,      2'b01, {1'b0, 32'h00000033});
        send(32'h1,        2'b10, {1'b0, 32'h00000063});
        send(32'hFC000001, 2'b10, {1'b0, 32'h00000063});
        send(32'h0,        2'b10, {1'b0, 32'h00000000});
        send(32'hFFFFFFFF, 2'b10, {1'b0, 32'hFFFFFFFF});
        send(32'h1234,     2'b11, {1'b1, 32'h00000000});
        in_valid = 1'b0;
        drain();
        check("enc_count_directed", 64'(enc_count), 64'(9));

        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            m = 2'($urandom_range(0, 3));
            send(d, m, model(d, m));
        end
        in_valid = 1'b0;
        drain();
        chk_lat = 0;
        check("enc_count_stream", 64'(enc_count), 64'(109));

        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("enc_count_cleared", 64'(enc_count), 64'(0));
        @(posedge clk);
        #1;
        rdy_rand = 1;
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            m = 2'($urandom_range(0, 3));
            send(d, m, model(d, m));
        end
        in_valid = 1'b0;
        drain();
        rdy_rand = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        check("enc_count_random_ready", 64'(enc_count), 64'(100));

        out_ready = 1'b0;
        send(32'hAAAA, 2'b01, model(32'hAAAA, 2'b01));
        send(32'h5555, 2'b10, model(32'h5555, 2'b10));
        in_valid = 1'b0;
        check("full_out_valid", 64'(out_valid), 64'(1));
        check("full_in_ready", 64'(in_ready), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_codeword", 64'(codeword_out), 64'(0));
        check("midrst_mode_err", 64'(mode_err), 64'(0));
        check("midrst_enc_count", 64'(enc_count), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_enc_count", 64'(enc_count), 64'(0));

        sat_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sat_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_count_two", 64'(sat_enc_count), 64'(2));
        sat_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sat_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_count_saturated", 64'(sat_enc_count), 64'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
